ex_muldiv: RTL

Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the register's `out_ra`/`out_rb` operands and its decoded mul/div control, and computes MULT/MULTU/DIV/DIVU over 32 radix-2 iterations into architectural HI/LO registers. It raises a busy flag so the hazard unit can stall MFHI/MFLO and later mul/div issue. It also services MTHI/MTLO writes.

---
 rtl/ex_muldiv_pkg.sv | 29 ++
 rtl/ex_muldiv_step.sv | 42 ++++
 rtl/ex_muldiv.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage iterative multiply/divide unit.
// Op encodings, FSM state type and datapath constants.
package ex_muldiv_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   // Quotient reported for any divide by zero.
   localparam logic [XLEN-1:0] DIV_ZERO_QUOT = {XLEN{1'b1}};

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StCalc = 2'd1,
      StFix  = 2'd2
   } muldiv_state_e;

   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/ex_muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
// acc_hi:acc_lo is the running product, or remainder:quotient for divide.
module muldiv_step
   import ex_muldiv_pkg::*;
#(
   parameter int unsigned P_XLEN = XLEN
) (
   input  logic              is_div,
   input  logic [P_XLEN-1:0] acc_hi,
   input  logic [P_XLEN-1:0] acc_lo,
   input  logic [P_XLEN-1:0] operand,
   output logic [P_XLEN-1:0] nxt_hi,
   output logic [P_XLEN-1:0] nxt_lo
);

   logic [P_XLEN:0]   sum;
   logic [P_XLEN:0]   shifted;
   logic [P_XLEN+1:0] diff;
   logic              fits;

   always_comb begin
      sum     = '0;
      shifted = '0;
      diff    = '0;
      fits    = 1'b0;
      nxt_hi  = acc_hi;
      nxt_lo  = acc_lo;
      if (is_div) begin
         // Remainder can reach 33 bits after the shift, so compare one bit wider.
         shifted = {acc_hi, acc_lo[P_XLEN-1]};
         diff    = {1'b0, shifted} - {2'b00, operand};
         fits    = ~diff[P_XLEN+1];
         nxt_hi  = fits ? diff[P_XLEN-1:0] : shifted[P_XLEN-1:0];
         nxt_lo  = {acc_lo[P_XLEN-2:0], fits};
      end else begin
         sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
         nxt_hi = sum[P_XLEN:1];
         nxt_lo = {sum[0], acc_lo[P_XLEN-1:1]};
      end
   end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One operation takes 32 CALC cycles plus one FIX cycle for sign correction.
module ex_muldiv
   import ex_muldiv_pkg::*;
#(
   parameter int unsigned P_XLEN = XLEN
) (
   input  logic              in_CLK,
   input  logic              in_CLR_N,
   input  logic              in_start,
   input  logic [1:0]        in_op,
   input  logic [P_XLEN-1:0] in_ra,
   input  logic [P_XLEN-1:0] in_rb,
   input  logic              in_flush,
   input  logic              in_wr_hi,
   input  logic              in_wr_lo,
   input  logic [P_XLEN-1:0] in_wdata,
   output logic              out_busy,
   output logic              out_done,
   output logic [P_XLEN-1:0] out_hi,
   output logic [P_XLEN-1:0] out_lo
);

   localparam int unsigned CntW = $clog2(P_XLEN);
   localparam logic [CntW-1:0] CntLast = CntW'(P_XLEN - 1);

   muldiv_state_e state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [P_XLEN-1:0] acc_hi_q, acc_hi_d;
   logic [P_XLEN-1:0] acc_lo_q, acc_lo_d;
   logic [P_XLEN-1:0] operand_q, operand_d;
   logic [P_XLEN-1:0] raw_a_q, raw_a_d;
   logic              is_div_q, is_div_d;
   logic              neg_res_q, neg_res_d;
   logic              neg_a_q, neg_a_d;
   logic              div_zero_q, div_zero_d;
   logic [P_XLEN-1:0] hi_q, hi_d;
   logic [P_XLEN-1:0] lo_q, lo_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [P_XLEN-1:0] step_hi, step_lo;

   logic              sign_a, sign_b;
   logic [P_XLEN-1:0] mag_a, mag_b;
   logic [2*P_XLEN-1:0] prod, prod_fix;

   muldiv_step #(
      .P_XLEN (P_XLEN)
   ) u_step (
      .is_div  (is_div_q),
      .acc_hi  (acc_hi_q),
      .acc_lo  (acc_lo_q),
      .operand (operand_q),
      .nxt_hi  (step_hi),
      .nxt_lo  (step_lo)
   );

   // Operand magnitudes; signed ops take absolute values, 0x80000000 stays unsigned 2^31.
   always_comb begin
      sign_a = op_is_signed(in_op) & in_ra[P_XLEN-1];
      sign_b = op_is_signed(in_op) & in_rb[P_XLEN-1];
      mag_a  = sign_a ? (~in_ra + 1'b1) : in_ra;
      mag_b  = sign_b ? (~in_rb + 1'b1) : in_rb;
   end

   always_comb begin
      prod     = {acc_hi_q, acc_lo_q};
      prod_fix = neg_res_q ? (~prod + 1'b1) : prod;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_hi_d   = acc_hi_q;
      acc_lo_d   = acc_lo_q;
      operand_d  = operand_q;
      raw_a_d    = raw_a_q;
      is_div_d   = is_div_q;
      neg_res_d  = neg_res_q;
      neg_a_d    = neg_a_q;
      div_zero_d = div_zero_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (in_start && !in_flush) begin
               state_d    = StCalc;
               cnt_d      = '0;
               is_div_d   = op_is_div(in_op);
               neg_res_d  = sign_a ^ sign_b;
               neg_a_d    = sign_a;
               raw_a_d    = in_ra;
               div_zero_d = (in_rb == '0);
               acc_hi_d   = '0;
               acc_lo_d   = op_is_div(in_op) ? mag_a : mag_b;
               operand_d  = op_is_div(in_op) ? mag_b : mag_a;
            end else if (!in_start) begin
               if (in_wr_hi) hi_d = in_wdata;
               if (in_wr_lo) lo_d = in_wdata;
            end
         end
         StCalc: begin
            if (in_flush) begin
               state_d = StIdle;
            end else begin
               acc_hi_d = step_hi;
               acc_lo_d = step_lo;
               cnt_d    = cnt_q + 1'b1;
               if (cnt_q == CntLast) state_d = StFix;
            end
         end
         StFix: begin
            state_d = StIdle;
            if (!in_flush) begin
               done_d = 1'b1;
               if (!is_div_q) begin
                  hi_d = prod_fix[2*P_XLEN-1:P_XLEN];
                  lo_d = prod_fix[P_XLEN-1:0];
               end else if (div_zero_q) begin
                  hi_d = raw_a_q;
                  lo_d = DIV_ZERO_QUOT[P_XLEN-1:0];
               end else begin
                  lo_d = neg_res_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
                  hi_d = neg_a_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge in_CLK or negedge in_CLR_N) begin
      if (!in_CLR_N) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         acc_hi_q   <= '0;
         acc_lo_q   <= '0;
         operand_q  <= '0;
         raw_a_q    <= '0;
         is_div_q   <= 1'b0;
         neg_res_q  <= 1'b0;
         neg_a_q    <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_hi_q   <= acc_hi_d;
         acc_lo_q   <= acc_lo_d;
         operand_q  <= operand_d;
         raw_a_q    <= raw_a_d;
         is_div_q   <= is_div_d;
         neg_res_q  <= neg_res_d;
         neg_a_q    <= neg_a_d;
         div_zero_q <= div_zero_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign out_busy = busy_q;
   assign out_done = done_q;
   assign out_hi   = hi_q;
   assign out_lo   = lo_q;

endmodule
